// File: rtl/muldiv_arbiter_pkg.sv
// Shared configuration for the mul/div arbiter: widths, op and FSM encodings.
package muldiv_arbiter_pkg;

    localparam int unsigned RW_DEFAULT = 16;

    typedef enum logic [1:0] {
        OpMul = 2'b00,
        OpDiv = 2'b01,
        OpMod = 2'b10,
        OpRsv = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StIssue = 2'b01,
        StWait  = 2'b10,
        StResp  = 2'b11
    } state_e;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker; the pointer advances past the winner only on an accept.
module arb_rr2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_gnt,
    output logic       o_idx
);

    logic r_ptr;
    logic w_idx;

    // Favoured requester wins if it asks, otherwise the other one.
    always_comb begin
        w_idx = i_req[r_ptr] ? r_ptr : ~r_ptr;
        o_gnt = 2'b00;
        if (i_req[w_idx]) begin
            o_gnt = w_idx ? 2'b10 : 2'b01;
        end
    end

    assign o_idx = w_idx;

    // Pointer then favours the requester that just lost.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= 1'b0;
        end else if (i_accept) begin
            r_ptr <= ~w_idx;
        end
    end

endmodule

// File: rtl/muldiv_arbiter.sv
// Shares one mul/div unit between two requesters; owns one op at a time.
module muldiv_arbiter
    import muldiv_arbiter_pkg::*;
#(
    parameter int unsigned RW = RW_DEFAULT
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [1:0]    i_req_valid,
    input  logic [3:0]    i_req_op,
    input  logic [2*RW-1:0] i_req_a,
    input  logic [2*RW-1:0] i_req_b,
    input  logic [1:0]    i_flush,
    output logic [1:0]    o_req_ready,
    output logic [1:0]    o_res_valid,
    output logic [RW-1:0] o_res_d,
    output logic [RW-1:0] o_md_a,
    output logic [RW-1:0] o_md_b,
    output logic          o_md_mul,
    output logic          o_md_div,
    output logic          o_md_mod,
    output logic          o_md_submit,
    output logic          o_md_flush,
    input  logic [RW-1:0] i_md_d,
    input  logic          i_md_busy
);

    state_e        r_state, w_state_nxt;
    op_e           r_op;
    logic [RW-1:0] r_a, r_b, r_res;
    logic          r_owner;

    logic [1:0]    w_gnt;
    logic          w_gnt_idx;
    logic          w_accept;
    logic          w_capture;
    logic          w_own_flush;
    op_e           w_sel_op;
    logic [RW-1:0] w_sel_a, w_sel_b;
    logic          w_bypass;
    logic [RW-1:0] w_bypass_res;
    logic          w_active;

    arb_rr2 u_arb (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_req    (i_req_valid & ~i_flush),
        .i_accept (w_accept),
        .o_gnt    (w_gnt),
        .o_idx    (w_gnt_idx)
    );

    assign w_sel_op    = op_e'(w_gnt_idx ? i_req_op[3:2] : i_req_op[1:0]);
    assign w_sel_a     = w_gnt_idx ? i_req_a[2*RW-1:RW] : i_req_a[RW-1:0];
    assign w_sel_b     = w_gnt_idx ? i_req_b[2*RW-1:RW] : i_req_b[RW-1:0];
    assign w_own_flush = i_flush[r_owner];
    assign w_active    = (r_state != StIdle);

    // Ops the unit never sees: reserved, and div/mod by zero.
    always_comb begin
        w_bypass     = (w_sel_op == OpRsv) ||
                       (((w_sel_op == OpDiv) || (w_sel_op == OpMod)) && (w_sel_b == '0));
        w_bypass_res = '0;
        if (w_sel_op == OpDiv) begin
            w_bypass_res = '1;
        end else if (w_sel_op == OpMod) begin
            w_bypass_res = w_sel_a;
        end
    end

    // Next-state and strobe outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        o_req_ready = 2'b00;
        o_res_valid = 2'b00;
        o_md_submit = 1'b0;
        o_md_flush  = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_gnt != 2'b00) begin
                    w_accept    = 1'b1;
                    o_req_ready = w_gnt;
                    w_state_nxt = w_bypass ? StResp : StIssue;
                end
            end
            StIssue: begin
                if (w_own_flush) begin
                    o_md_flush  = 1'b1;
                    w_state_nxt = StIdle;
                end else begin
                    o_md_submit = 1'b1;
                    w_state_nxt = StWait;
                end
            end
            StWait: begin
                if (w_own_flush) begin
                    o_md_flush  = 1'b1;
                    w_state_nxt = StIdle;
                end else if (!i_md_busy) begin
                    w_capture   = 1'b1;
                    w_state_nxt = StResp;
                end
            end
            StResp: begin
                if (!w_own_flush) begin
                    o_res_valid = r_owner ? 2'b10 : 2'b01;
                end
                w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // State, latched request and result registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_op    <= OpMul;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_owner <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op    <= w_sel_op;
                r_a     <= w_sel_a;
                r_b     <= w_sel_b;
                r_owner <= w_gnt_idx;
                r_res   <= w_bypass_res;
            end else if (w_capture) begin
                r_res <= i_md_d;
            end
        end
    end

    assign o_res_d  = r_res;
    assign o_md_a   = r_a;
    assign o_md_b   = r_b;
    assign o_md_mul = w_active && (r_op == OpMul);
    assign o_md_div = w_active && (r_op == OpDiv);
    assign o_md_mod = w_active && (r_op == OpMod);

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Directed plus randomized bench for muldiv_arbiter with a behavioural mul/div unit.
module tb_muldiv_arbiter;

    localparam int RW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    req_valid = '0;
    logic [3:0]    req_op = '0;
    logic [2*RW-1:0] req_a = '0;
    logic [2*RW-1:0] req_b = '0;
    logic [1:0]    flush = '0;
    logic [1:0]    o_req_ready, o_res_valid;
    logic [RW-1:0] o_res_d, o_md_a, o_md_b;
    logic          o_md_mul, o_md_div, o_md_mod, o_md_submit, o_md_flush;
    logic [RW-1:0] md_d = '0;
    logic          md_busy = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int sub_cnt = 0;
    int res_cnt = 0;

    muldiv_arbiter #(.RW(RW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .i_req_op    (req_op),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .i_flush     (flush),
        .o_req_ready (o_req_ready),
        .o_res_valid (o_res_valid),
        .o_res_d     (o_res_d),
        .o_md_a      (o_md_a),
        .o_md_b      (o_md_b),
        .o_md_mul    (o_md_mul),
        .o_md_div    (o_md_div),
        .o_md_mod    (o_md_mod),
        .o_md_submit (o_md_submit),
        .o_md_flush  (o_md_flush),
        .i_md_d      (md_d),
        .i_md_busy   (md_busy)
    );

    always #5 clk = ~clk;

    // Unit model: busy the cycle after submit; mul done 16 cycles after submit, div/mod 17.
    int            md_cnt = 0;
    logic [RW-1:0] md_pend = '0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_md_submit) sub_cnt <= sub_cnt + 1;
        if (o_res_valid != 2'b00) res_cnt <= res_cnt + 1;
        if (rst || o_md_flush) begin
            md_busy <= 1'b0;
            md_cnt  <= 0;
        end else if (o_md_submit) begin
            md_busy <= 1'b1;
            md_cnt  <= o_md_mul ? 15 : 16;
            md_pend <= o_md_mul ? o_md_a * o_md_b :
                       o_md_div ? o_md_a / o_md_b : o_md_a % o_md_b;
        end else if (md_busy) begin
            if (md_cnt == 1) begin
                md_busy <= 1'b0;
                md_d    <= md_pend;
            end else begin
                md_cnt <= md_cnt - 1;
            end
        end
    end

    function automatic logic [RW-1:0] ref_res(input logic [1:0] op, input logic [RW-1:0] a,
                                              input logic [RW-1:0] b);
        case (op)
            2'd0:    return a * b;
            2'd1:    return (b == 0) ? {RW{1'b1}} : a / b;
            2'd2:    return (b == 0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [RW-1:0] b);
        if (op == 2'd3) return 1;
        if (op != 2'd0 && b == 0) return 1;
        return (op == 2'd0) ? 18 : 19;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input int n, input logic [1:0] op, input logic [RW-1:0] a,
                             input logic [RW-1:0] b);
        req_valid[n]       = 1'b1;
        req_op[2*n +: 2]   = op;
        req_a[RW*n +: RW]  = a;
        req_b[RW*n +: RW]  = b;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Bounded wait for ready[n]; returns accept cycle or -1.
    task automatic wait_ready(input int n, output int t);
        t = -1;
        for (int i = 0; i < 40; i++) begin
            if (o_req_ready[n]) begin
                t = cyc;
                break;
            end
            step();
        end
    endtask

    task automatic wait_res(output int t);
        t = -1;
        for (int i = 0; i < 40; i++) begin
            if (o_res_valid != 2'b00) begin
                t = cyc;
                break;
            end
            step();
        end
    endtask

    task automatic do_req(input int n, input logic [1:0] op, input logic [RW-1:0] a,
                          input logic [RW-1:0] b, input string tag);
        int t_acc, t_res, s0, lat;
        lat = ref_lat(op, b);
        s0  = sub_cnt;
        @(negedge clk);
        drive_req(n, op, a, b);
        #1;
        wait_ready(n, t_acc);
        check({tag, " accepted"}, 64'(t_acc >= 0), 64'd1);
        @(negedge clk);
        req_valid[n] = 1'b0;
        #1;
        wait_res(t_res);
        check({tag, " latency"}, 64'(t_res - t_acc), 64'(lat));
        check({tag, " owner"}, 64'(o_res_valid), 64'(n == 0 ? 2'b01 : 2'b10));
        check({tag, " data"}, 64'(o_res_d), 64'(ref_res(op, a, b)));
        step();
        check({tag, " pulse"}, 64'(o_res_valid), 64'd0);
        check({tag, " submits"}, 64'(sub_cnt - s0), 64'(lat == 1 ? 0 : 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, r0, ovl;
        logic [1:0] op;
        logic [RW-1:0] a, b;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset outputs", {o_req_ready, o_res_valid, o_res_d, o_md_a, o_md_b, o_md_mul,
                                o_md_div, o_md_mod, o_md_submit, o_md_flush}, 64'd0);

        do_req(0, 2'd0, 16'd7, 16'd6, "mul7x6");
        do_req(1, 2'd1, 16'd100, 16'd7, "div100/7");
        do_req(1, 2'd2, 16'd100, 16'd7, "mod100%7");

        // Round-robin from reset pointer: both valid, req0 first, no overlap.
        @(negedge clk);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive_req(0, 2'd0, 16'd3, 16'd3);
        drive_req(1, 2'd0, 16'd4, 16'd4);
        #1;
        check("rr first ready", 64'(o_req_ready), 64'd1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        #1;
        ovl = 0;
        for (int i = 0; i < 40 && o_res_valid == 2'b00; i++) begin
            if (o_req_ready != 2'b00) ovl++;
            step();
        end
        check("rr no overlap", 64'(ovl), 64'd0);
        check("rr first owner", 64'(o_res_valid), 64'd1);
        check("rr first data", 64'(o_res_d), 64'd9);
        step();
        check("rr second ready", 64'(o_req_ready), 64'd2);
        @(negedge clk);
        req_valid[1] = 1'b0;
        #1;
        wait_res(t1);
        check("rr second owner", 64'(o_res_valid), 64'd2);
        check("rr second data", 64'(o_res_d), 64'd16);

        // Divide-by-zero and reserved bypasses.
        do_req(0, 2'd1, 16'd5, 16'd0, "div5/0");
        do_req(0, 2'd2, 16'd5, 16'd0, "mod5%0");
        do_req(1, 2'd3, 16'd9, 16'd9, "reserved");

        // Flushing requester is masked from grant in IDLE.
        step();
        drive_req(0, 2'd3, 16'd1, 16'd1);
        drive_req(1, 2'd3, 16'd1, 16'd1);
        flush[0] = 1'b1;
        #1;
        check("flush mask ready", 64'(o_req_ready), 64'd2);
        @(negedge clk);
        req_valid = 2'b00;
        flush = 2'b00;
        #1;
        check("flush mask owner", 64'(o_res_valid), 64'd2);

        // Owner flush mid-op.
        step();
        r0 = res_cnt;
        drive_req(1, 2'd1, 16'd100, 16'd7);
        #1;
        wait_ready(1, t0);
        @(negedge clk);
        req_valid[1] = 1'b0;
        while (cyc < t0 + 5) @(negedge clk);
        flush[1] = 1'b1;
        #1;
        check("flush strobe", 64'(o_md_flush), 64'd1);
        @(negedge clk);
        flush[1] = 1'b0;
        repeat (25) step();
        check("flush no result", 64'(res_cnt - r0), 64'd0);
        do_req(1, 2'd0, 16'd12, 16'd11, "after flush");

        // Non-owner flush during an op has no effect.
        fork
            do_req(0, 2'd0, 16'd300, 16'd5, "nonowner flush");
            begin
                repeat (5) @(negedge clk);
                flush[1] = 1'b1;
                repeat (3) @(negedge clk);
                flush[1] = 1'b0;
            end
        join

        // Owner flush in RESP suppresses the result.
        step();
        r0 = res_cnt;
        drive_req(0, 2'd1, 16'd5, 16'd0);
        #1;
        wait_ready(0, t0);
        @(negedge clk);
        req_valid[0] = 1'b0;
        flush[0] = 1'b1;
        #1;
        check("resp flush valid", 64'(o_res_valid), 64'd0);
        @(negedge clk);
        flush[0] = 1'b0;
        step();
        check("resp flush count", 64'(res_cnt - r0), 64'd0);

        // Reset mid-div.
        r0 = res_cnt;
        drive_req(0, 2'd1, 16'd100, 16'd3);
        #1;
        wait_ready(0, t0);
        @(negedge clk);
        req_valid[0] = 1'b0;
        while (cyc < t0 + 8) @(negedge clk);
        rst = 1'b1;
        step();
        check("midop reset outputs", {o_req_ready, o_res_valid, o_res_d, o_md_a, o_md_b,
                                      o_md_mul, o_md_div, o_md_mod, o_md_submit, o_md_flush},
              64'd0);
        rst = 1'b0;
        repeat (20) step();
        check("midop reset no result", 64'(res_cnt - r0), 64'd0);
        do_req(0, 2'd0, 16'd2, 16'd2, "mul2x2");

        // Randomized traffic.
        for (int i = 0; i < 20; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = 16'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            do_req(int'($urandom_range(0, 1)), op, a, b, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_arbiter.md
MULDIV_ARBITER -- requirements
Module: muldiv_arbiter

Interface
REQ-001 SHALL have parameter RW, default `RW (16), operand/result width.
REQ-002 SHALL have port i_clk  in  1  clock; reset i_rst, synchronous, active-high; clock i_clk.
REQ-003 SHALL have port i_rst  in  1  synchronous active-high reset.
REQ-004 SHALL have port i_req_valid  in  2  per-requester request valid (bit n = requester n).
REQ-005 SHALL have port i_req_op  in  4  op per requester, [2n+1:2n]: 00 mul, 01 div, 10 mod, 11 reserved.
REQ-006 SHALL have port i_req_a  in  2*RW  operand A per requester, [RW*n +: RW].
REQ-007 SHALL have port i_req_b  in  2*RW  operand B per requester, [RW*n +: RW].
REQ-008 SHALL have port i_flush  in  2  per-requester flush of its in-flight op.
REQ-009 SHALL have port o_req_ready  out  2  accept strobe; handshake = valid & ready.
REQ-010 SHALL have port o_res_valid  out  2  one-cycle result strobe to owning requester.
REQ-011 SHALL have port o_res_d  out  RW  result, meaningful only when o_res_valid != 0.
REQ-012 SHALL have ports o_md_a, o_md_b  out  RW  held operands to the mul/div unit.
REQ-013 SHALL have ports o_md_mul, o_md_div, o_md_mod  out  1  op select to the unit (one-hot or all 0).
REQ-014 SHALL have ports o_md_submit, o_md_flush  out  1  start and abort strobes to the unit.
REQ-015 SHALL have ports i_md_d  in  RW  unit result, and i_md_busy  in  1  unit busy.

Function
REQ-016 SHALL implement FSM IDLE, ISSUE, WAIT, RESP.
REQ-017 IDLE: SHALL grant one valid, non-flushing requester by 2-way round-robin; o_req_ready[winner]=1 combinationally that cycle; latch op/a/b/owner; pointer then favours the other requester.
REQ-018 Both valid with pointer at reset value SHALL grant requester 0 first.
REQ-019 o_req_ready SHALL be 0 in every state except IDLE; requester holds valid/operands until accepted.
REQ-020 Accepted div/mod with b==0 SHALL bypass the unit: IDLE->RESP, div result {RW{1}}, mod result = a.
REQ-021 Accepted op 11 SHALL bypass the unit: IDLE->RESP, result 0.
REQ-022 Otherwise IDLE->ISSUE; ISSUE asserts o_md_submit for exactly 1 cycle, then ->WAIT.
REQ-023 o_md_a/b/op selects SHALL be driven from latched registers and held stable from ISSUE until return to IDLE.
REQ-024 WAIT: first cycle with i_md_busy=0 SHALL capture i_md_d into the result register and ->RESP.
REQ-025 RESP: o_res_valid[owner]=1 for 1 cycle with o_res_d = captured result; ->IDLE.
REQ-026 Latency accept(T)->RESP: mul T+18, div/mod T+19, bypass T+1.
REQ-027 i_flush[owner] in ISSUE or WAIT SHALL assert o_md_flush for 1 cycle, drop the op, and go to IDLE with no o_res_valid.
REQ-028 i_flush[owner] in RESP SHALL suppress o_res_valid; FSM still goes to IDLE.
REQ-029 i_flush of the non-owner SHALL have no effect; in IDLE it masks that requester from grant that cycle.
REQ-030 Round-robin pointer SHALL update only on an accepted handshake.

Reset
REQ-031 On i_rst: state IDLE, pointer favours requester 0, all outputs 0, latched registers 0.
REQ-032 i_rst mid-operation SHALL abandon the op with no o_res_valid; the unit is reset by the same i_rst.

Structure
REQ-033 RW, op encodings and FSM state encodings SHALL live in the shared config include.
REQ-034 The 2-way round-robin picker SHALL be a sub-module named arb_rr2.

Verification
REQ-035 Req0 mul a=7 b=6 -> ready[0] at T; submit at T+1; o_res_valid=01, o_res_d=42 at T+18.
REQ-036 Req1 div a=100 b=7 then mod with the same operands -> results 14 at T+19, then 2.
REQ-037 Both valid after reset, mul 3*3 and mul 4*4 -> req0 served first (9), then req1 (16); no overlap.
REQ-038 Req0 div a=5 b=0 -> no o_md_submit, o_res_d=16'hFFFF at T+1; mod a=5 b=0 -> 5.
REQ-039 Req1 div accepted, i_flush[1] at T+5 -> o_md_flush at T+5, no o_res_valid, next request accepted from IDLE.
REQ-040 i_rst at T+8 of div -> all outputs 0 next cycle; a new mul 2*2 returns 4 normally.
